// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the FP adder host: FSM states, default widths
// and the layout of the serial setup word.
package fp_adder_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int SETUP_W_DEF   = 8;
  localparam int SU_SUB_LSB    = 5;
  localparam int SU_LANE_LSB   = 1;
  localparam int SU_INTCLK_BIT = 0;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, READ, DONE} state_e;

  // Bit 0 stays low so the device runs from its internal clock.
  function automatic logic [SETUP_W_DEF-1:0] make_setup(input logic [2:0] sub_op,
                                                        input logic [3:0] lane_en);
    logic [SETUP_W_DEF-1:0] w;
    w                   = '0;
    w[SU_SUB_LSB +: 3]  = sub_op;
    w[SU_LANE_LSB +: 4] = lane_en;
    w[SU_INTCLK_BIT]    = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/fp_host_shifter.sv
// Multi-lane parallel-load, MSB-first shift register with a shared bit counter;
// used both to serialise operands and to deserialise the device result.
module fp_host_shifter #(
  parameter  int LANES = 1,
  parameter  int W     = 32,
  localparam int CW    = $clog2(W + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [LANES-1:0][W-1:0]   load_val_i,
  input  logic                      shift_i,
  input  logic [LANES-1:0]          ser_i,
  output logic [LANES-1:0]          ser_o,
  output logic [LANES-1:0][W-1:0]   par_o,
  output logic [CW-1:0]             cnt_o
);

  logic [LANES-1:0][W-1:0] sr_q, sr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_val_i;
      cnt_d = '0;
    end else if (shift_i) begin
      for (int l = 0; l < LANES; l++) sr_d[l] = {sr_q[l][W-2:0], ser_i[l]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign ser_o[l] = sr_q[l][W-1];
  end

  assign par_o = sr_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/fp_adder_host.sv
// Host-side controller for a serial FP adder: ships four operands plus a setup
// word, waits (bounded) for ready, then reads the serial result back.
module fp_adder_host
  import fp_adder_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SETUP_W  = SETUP_W_DEF,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic [2:0]        sub_op_in,
  input  logic [3:0]        lane_en_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              timeout_out,
  output logic [DATA_W-1:0] result_out,
  output logic              dev_serial1_out,
  output logic              dev_serial2_out,
  output logic              dev_serial3_out,
  output logic              dev_serial4_out,
  output logic              dev_setup_serial_out,
  output logic              dev_wr_out,
  output logic              dev_output_read_out,
  input  logic              dev_output_rdy_in,
  input  logic              dev_serial_in
);

  localparam int RD_CYC   = DATA_W + READ_LAT;
  localparam int CNT_MAX  = (TIMEOUT > RD_CYC) ? TIMEOUT : RD_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BC_W     = $clog2(DATA_W + 1);
  localparam int TX_LANES = 5;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              to_q, to_d;

  logic [TX_LANES-1:0][DATA_W-1:0] tx_val, tx_par;
  logic [TX_LANES-1:0]             tx_ser;
  logic [BC_W-1:0]                 tx_cnt, rx_cnt;
  logic [0:0][DATA_W-1:0]          rx_par;
  logic [0:0]                      rx_ser;
  logic                            tx_load, rx_load, rx_shift, in_load;
  logic [SETUP_W-1:0]              setup_w;
  logic                            unused_ok;

  // The setup word rides as a fifth lane, zero-padded so it lands in the last SETUP_W bits.
  assign setup_w = SETUP_W'(make_setup(sub_op_in, lane_en_in));
  assign tx_val  = {{{(DATA_W-SETUP_W){1'b0}}, setup_w}, a_in, b_in, c_in, d_in};
  assign in_load = (state_q == LOAD);

  fp_host_shifter #(.LANES(TX_LANES), .W(DATA_W)) u_tx (
    .clk_i(clk_in), .rst_i(rst_in), .load_i(tx_load), .load_val_i(tx_val),
    .shift_i(in_load), .ser_i('0), .ser_o(tx_ser), .par_o(tx_par), .cnt_o(tx_cnt)
  );

  fp_host_shifter #(.LANES(1), .W(DATA_W)) u_rx (
    .clk_i(clk_in), .rst_i(rst_in), .load_i(rx_load), .load_val_i('0),
    .shift_i(rx_shift), .ser_i(dev_serial_in), .ser_o(rx_ser), .par_o(rx_par), .cnt_o(rx_cnt)
  );

  assign unused_ok = ^{tx_par, rx_cnt, rx_ser};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    to_d     = 1'b0;
    tx_load  = 1'b0;
    rx_load  = 1'b0;
    rx_shift = 1'b0;
    unique case (state_q)
      IDLE: if (start_in) begin
        state_d = LOAD;
        tx_load = 1'b1;
      end
      LOAD: if (tx_cnt == BC_W'(DATA_W - 1)) begin
        state_d = WAIT_RDY;
        cnt_d   = '0;
      end
      WAIT_RDY: begin
        if (dev_output_rdy_in) begin
          state_d = READ;
          cnt_d   = '0;
          rx_load = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        rx_shift = (cnt_q >= CNT_W'(READ_LAT));
        // Final bit is taken straight from the pin so result updates exactly at exit.
        if (cnt_q == CNT_W'(RD_CYC - 1)) begin
          state_d  = DONE;
          result_d = {rx_par[0][DATA_W-2:0], dev_serial_in};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      to_q     <= to_d;
    end
  end

  assign busy_out             = (state_q != IDLE);
  assign done_out             = (state_q == DONE);
  assign timeout_out          = (state_q == DONE) && to_q;
  assign result_out           = result_q;
  assign dev_wr_out           = in_load;
  assign dev_serial1_out      = in_load & tx_ser[0];
  assign dev_serial2_out      = in_load & tx_ser[1];
  assign dev_serial3_out      = in_load & tx_ser[2];
  assign dev_serial4_out      = in_load & tx_ser[3];
  assign dev_setup_serial_out = in_load & tx_ser[4];
  assign dev_output_read_out  = (state_q == READ) && (cnt_q < CNT_W'(DATA_W));

endmodule

// File: tb/tb_fp_adder_host.sv
// Directed bench for fp_adder_host: two builds (READ_LAT 1 and 2) share stimulus,
// each talks to a behavioural serial device that answers with a fixed word.
module tb_fp_adder_host;

  localparam int DW  = 32;
  localparam int TO  = 1024;
  localparam int DLY = 5;

  typedef struct {
    logic [31:0] a, b, c, d;
    logic [2:0]  sub;
    logic [3:0]  lane;
    logic [31:0] dres;
    logic [7:0]  setup;
  } vec_t;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in;
  logic [DW-1:0] a_in, b_in, c_in, d_in;
  logic [2:0]    sub_op_in;
  logic [3:0]    lane_en_in;
  logic [1:0]    busy, done, tmo, s1, s2, s3, s4, sset, wr, rd, rdy, ser;
  logic [DW-1:0] res0, res1;
  int            cyc = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  fp_adder_host #(.DATA_W(DW), .SETUP_W(8), .READ_LAT(1), .TIMEOUT(TO)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .sub_op_in(sub_op_in), .lane_en_in(lane_en_in),
    .busy_out(busy[0]), .done_out(done[0]), .timeout_out(tmo[0]), .result_out(res0),
    .dev_serial1_out(s1[0]), .dev_serial2_out(s2[0]), .dev_serial3_out(s3[0]),
    .dev_serial4_out(s4[0]), .dev_setup_serial_out(sset[0]), .dev_wr_out(wr[0]),
    .dev_output_read_out(rd[0]), .dev_output_rdy_in(rdy[0]), .dev_serial_in(ser[0])
  );

  fp_adder_host #(.DATA_W(DW), .SETUP_W(8), .READ_LAT(2), .TIMEOUT(TO)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .sub_op_in(sub_op_in), .lane_en_in(lane_en_in),
    .busy_out(busy[1]), .done_out(done[1]), .timeout_out(tmo[1]), .result_out(res1),
    .dev_serial1_out(s1[1]), .dev_serial2_out(s2[1]), .dev_serial3_out(s3[1]),
    .dev_serial4_out(s4[1]), .dev_setup_serial_out(sset[1]), .dev_wr_out(wr[1]),
    .dev_output_read_out(rd[1]), .dev_output_rdy_in(rdy[1]), .dev_serial_in(ser[1])
  );

  // Device model: ready DLY cycles into the wait, result bits from READ cycle lat on.
  logic          dev_en;
  logic [DW-1:0] dev_val [2];
  int            wcnt [2], rc [2];
  bit            waiting [2], rd_act [2], pwr [2], prd [2];

  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 2;
      if (rst_in) begin
        rdy[i] = 1'b0; ser[i] = 1'b0; waiting[i] = 0; rd_act[i] = 0;
      end else begin
        if (pwr[i] && !wr[i]) begin waiting[i] = dev_en; wcnt[i] = 0; end
        else if (waiting[i]) wcnt[i]++;
        if (waiting[i] && wcnt[i] == DLY) begin rdy[i] = 1'b1; waiting[i] = 0; end
        if (rd[i] && !prd[i]) begin rdy[i] = 1'b0; rd_act[i] = 1; rc[i] = 0; end
        else if (rd_act[i]) rc[i]++;
        if (rd_act[i] && rc[i] >= lat && rc[i] < lat + DW) ser[i] = dev_val[i][DW-1-(rc[i]-lat)];
        else ser[i] = 1'b0;
        if (rd_act[i] && rc[i] >= lat + DW - 1) rd_act[i] = 0;
      end
      pwr[i] = wr[i];
      prd[i] = rd[i];
    end
  end

  // Monitor: captures the serial lanes and counts strobes/pulses since last clear.
  bit            clr_mon;
  int            wr_cnt, to_cnt, to_done, stray, pdone_cyc;
  int            rd_cnt [2], done_cnt [2], done_cyc [2];
  logic [DW-1:0] cap [5];

  always @(negedge clk_in) begin
    if (clr_mon) begin
      wr_cnt = 0; to_cnt = 0; to_done = 0; stray = 0; pdone_cyc = 0;
      for (int i = 0; i < 2; i++) begin rd_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0; end
      for (int j = 0; j < 5; j++) cap[j] = '0;
    end else begin
      if (wr[0]) begin
        wr_cnt++;
        cap[0] = {cap[0][DW-2:0], s1[0]};
        cap[1] = {cap[1][DW-2:0], s2[0]};
        cap[2] = {cap[2][DW-2:0], s3[0]};
        cap[3] = {cap[3][DW-2:0], s4[0]};
        cap[4] = {cap[4][DW-2:0], sset[0]};
      end else if (s1[0] | s2[0] | s3[0] | s4[0] | sset[0]) stray++;
      for (int i = 0; i < 2; i++) begin
        if (rd[i]) rd_cnt[i]++;
        if (done[i]) begin
          done_cnt[i]++;
          if (i == 0) pdone_cyc = done_cyc[0];
          done_cyc[i] = cyc;
        end
      end
      if (tmo[0]) to_cnt++;
      if (tmo[0] && done[0]) to_done++;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic launch(input vec_t v, output int x);
    a_in = v.a; b_in = v.b; c_in = v.c; d_in = v.d;
    sub_op_in = v.sub; lane_en_in = v.lane; dev_val[0] = v.dres;
    clr_mon = 1; tick(); clr_mon = 0;
    start_in = 1'b1; x = cyc;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    while (done_cnt[0] == 0 && k < budget) begin tick(); k++; end
    if (done_cnt[0] == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: no done_out within %0d cycles", nm, budget);
    end
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int x;
    launch(v, x);
    wait_done(200, nm);
    chk({nm, " wr cycles"}, wr_cnt, 32);
    chk({nm, " lane4 a"}, cap[3], v.a);
    chk({nm, " lane3 b"}, cap[2], v.b);
    chk({nm, " lane2 c"}, cap[1], v.c);
    chk({nm, " lane1 d"}, cap[0], v.d);
    chk({nm, " setup"}, cap[4], {24'h0, v.setup});
    chk({nm, " result"}, res0, v.dres);
    chk({nm, " latency"}, done_cyc[0] - x, 72);
    chk({nm, " done count"}, done_cnt[0], 1);
    chk({nm, " timeout"}, to_cnt, 0);
    chk({nm, " read cycles"}, rd_cnt[0], 32);
    chk({nm, " stray dev bits"}, stray, 0);
    chk({nm, " lat2 result"}, res1, 32'hA5A5A5A5);
    chk({nm, " lat2 read cycles"}, rd_cnt[1], 32);
    chk({nm, " lat2 latency"}, done_cyc[1] - x, 73);
  endtask

  vec_t vt [4];

  initial begin
    int x, k;
    vt[0] = '{32'h3F800000, 32'h40000000, 32'h0, 32'h0, 3'b000, 4'b1100, 32'h40400000, 8'h18};
    vt[1] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0F0F0F0F, 3'b101, 4'b1111, 32'h80000001, 8'hBE};
    vt[2] = '{32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 3'b010, 4'b0001, 32'hFFFFFFFF, 8'h42};
    vt[3] = '{32'h80000000, 32'h00000001, 32'h7F7FFFFF, 32'hFF800000, 3'b111, 4'b0000, 32'h13579BDF, 8'hE0};

    rst_in = 1'b1; start_in = 1'b0; dev_en = 1'b1; clr_mon = 0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0; sub_op_in = '0; lane_en_in = '0;
    dev_val[0] = '0; dev_val[1] = 32'hA5A5A5A5;
    repeat (3) tick();
    chk("reset busy", busy, 2'b00);
    chk("reset result", res0, 32'h0);
    chk("reset dev outs", {wr, rd, s1, s2, s3, s4, sset}, 14'h0);
    chk("reset done", {done, tmo}, 4'h0);
    rst_in = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // No ready: both builds time out, result held from the previous read.
    dev_en = 1'b0;
    launch(vt[2], x);
    wait_done(1200, "timeout");
    chk("timeout latency", done_cyc[0] - x, 32 + TO + 1);
    chk("timeout with done", to_done, 1);
    chk("timeout pulses", to_cnt, 1);
    chk("timeout done count", done_cnt[0], 1);
    chk("timeout result held", res0, 32'h13579BDF);
    chk("timeout no read", rd_cnt[0], 0);
    chk("timeout lat2 result held", res1, 32'hA5A5A5A5);
    dev_en = 1'b1;

    // Reset in LOAD cycle 10, with start asserted alongside it.
    launch(vt[1], x);
    while (cyc < x + 11) tick();
    rst_in = 1'b1; start_in = 1'b1;
    tick();
    chk("midload rst busy", busy, 2'b00);
    chk("midload rst dev outs", {wr, rd, s1, s2, s3, s4, sset}, 14'h0);
    chk("midload rst result", {res0, res1}, 64'h0);
    chk("midload rst done", {done, tmo}, 4'h0);
    rst_in = 1'b0; start_in = 1'b0;
    tick();
    chk("post rst idle", busy, 2'b00);
    run_vec(vt[0], "post rst");

    // start held high: back-to-back runs, each accepted only from IDLE.
    a_in = vt[1].a; b_in = vt[1].b; c_in = vt[1].c; d_in = vt[1].d;
    sub_op_in = vt[1].sub; lane_en_in = vt[1].lane; dev_val[0] = vt[1].dres;
    clr_mon = 1; tick(); clr_mon = 0;
    start_in = 1'b1; x = cyc;
    k = 0;
    while (done_cnt[0] < 3 && k < 400) begin tick(); k++; end
    start_in = 1'b0;
    if (done_cnt[0] < 3) begin
      n_chk++; n_err++;
      $display("FAIL b2b: only %0d done pulses within 400 cycles", done_cnt[0]);
    end
    chk("b2b third done", done_cyc[0] - x, 72 + 2 * 73);
    chk("b2b spacing", done_cyc[0] - pdone_cyc, 73);
    chk("b2b wr cycles", wr_cnt, 96);
    repeat (100) tick();
    chk("b2b done count", done_cnt[0], 3);
    chk("b2b lat2 done count", done_cnt[1], 3);
    chk("b2b idle", busy, 2'b00);
    chk("b2b result", res0, vt[1].dres);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
